pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register for the RV32IM pipeline; replaces the fixed-field, always-load inter-stage registers (IF/ID, ID/EX, EX/MA, MA/WB).
- Carries an opaque payload bus with a valid/ready handshake, flush (bubble insertion) and stall (backpressure).
- Optional two-entry skid mode registers the upstream ready so long stall paths are cut.

Parameters:
- PAYLOAD_W, 71, payload width in bits (MA/WB default: MUX3_select 1 + regwrite_enable 1 + ALU_out 32 + read_data 32 + rd 5).
- SKID, 0, 0 = single entry with combinational ready; 1 = two entries (main + skid) with registered in_ready.
- CLEAR_ON_BUBBLE, 1, 1 = out_payload forced to all-zero whenever out_valid = 0, so regwrite_enable reads 0 on bubbles; 0 = stale payload held.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- flush  input  1  discard all held entries this cycle.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept; transfer when in_valid & in_ready.
- in_payload  input  PAYLOAD_W  upstream payload.
- out_valid  output  1  out_payload valid.
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
- out_payload  output  PAYLOAD_W  oldest held payload.
- occupancy  output  2  entries held (0..1 when SKID=0, 0..2 when SKID=1).

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: out_valid = 0, out_payload = 0, occupancy = 0, all entries empty.
  - in_ready = 1 as soon as RESET deasserts (SKID=1: the register resets to 1).
- Latency: payload accepted at edge N appears on out_payload after edge N (1 cycle).
  - There is no combinational in-to-out path in either mode.
- Ordering: strict FIFO. A payload is never duplicated or dropped, except by flush.
- SKID=0:
  - in_ready = !full | out_ready. This is combinational from out_ready.
  - Accept while full and draining: the new payload replaces the drained one on the same edge and occupancy stays 1.
  - Full with out_ready = 0: hold the payload and keep out_valid = 1 (stall).
- SKID=1:
  - in_ready is a flop: 1 iff the skid entry is empty after the edge.
  - Accept into main if main is empty, or if main drains while skid is empty. Otherwise accept into skid.
  - When main drains and skid is full: skid moves to main, skid empties, and in_ready rises on the following cycle.
  - Main + skid full and out_ready = 0: in_ready = 0 and nothing moves.
  - out_payload is driven only from main.
- occupancy = number of valid entries after the edge. It never exceeds the mode maximum.
- Flush:
  - Wins over every other event in the cycle. After the edge all entries are empty, out_valid = 0 and occupancy = 0.
  - Any in_valid & in_ready transfer in the flush cycle counts as accepted and is discarded.
  - Any out transfer in the flush cycle is still valid downstream, because out_* reflect the pre-edge state.
- Bubbles: when out_valid = 0 and CLEAR_ON_BUBBLE = 1, out_payload = 0.
- Reset mid-operation: all entries are cleared immediately (asynchronously) and held entries are lost. After deassertion the stage behaves as if freshly reset.
- Holding: out_valid & !out_ready keeps out_payload stable, bit-for-bit, until the transfer completes or a flush occurs.

Decomposition:
- Shared package pipe_pkg holds:
  - XLEN = 32 and REG_ADDR_W = 5.
  - The per-stage payload widths: MA_WB_PAYLOAD_W = 71, plus the EX/MA, ID/EX and IF/ID widths.
  - Field LSB offsets for packing and unpacking the MA/WB payload (rd at bit 0, read_data at 5, ALU_out at 37, regwrite_enable at 69, MUX3_select at 70).
- One sub-module, pipe_slot: a PAYLOAD_W data register plus valid flop with load, clear and async reset. It is instantiated once (SKID=0) or twice (SKID=1).

Test Plan:
1. Streaming: SKID=0, out_ready = 1, in_valid = 1 for 4 cycles with payloads 0x11..0x14 -> out_valid = 1 from the cycle after the first; out_payload = 0x11, 0x12, 0x13, 0x14 on consecutive cycles; occupancy stays 1.
2. Stall: SKID=1, out_ready = 0, feed 0xAA, 0xBB, 0xCC -> 0xAA and 0xBB accepted; in_ready = 0 after the second accept; occupancy = 2; out_payload = 0xAA held. Then raise out_ready -> outputs 0xAA, 0xBB, 0xCC in order, with in_ready back to 1 the cycle after the skid empties.
3. Flush with a simultaneous accept: occupancy = 2, assert flush together with in_valid = 1 (payload 0x55) -> next cycle out_valid = 0, occupancy = 0, out_payload = 0; 0x55 never appears.
4. Bubble clearing: CLEAR_ON_BUBBLE = 1, MA/WB packing with regwrite_enable = 1 and rd = 5'd7, then in_valid = 0 -> after the drain, out_payload = 0, so the unpacked regwrite_enable = 0.
5. Async reset mid-stall: occupancy = 2, pulse RESET between clock edges -> out_valid, out_payload and occupancy go to 0 before the next edge; in_ready = 1 after deassertion; a subsequent 0x77 passes with 1-cycle latency.
6. Random handshake: 10k cycles, random in_valid, out_ready and rare flush, in both SKID modes -> scoreboard confirms FIFO order, no loss except flushed entries, payload stable while stalled, and occupancy bounds hold.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32IM inter-stage registers: widths, MA/WB field layout
// and the packing helpers used by the stages around pipe_stage_reg.
package pipe_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // pc + instr
    localparam int unsigned IF_ID_PAYLOAD_W = 2 * XLEN;
    // alu_op 4, alu_src, mem_read, mem_write, regwrite_enable, MUX3_select,
    // pc, rs1 data, rs2 data, imm, rd
    localparam int unsigned ID_EX_PAYLOAD_W = 4 + 5 + 4 * XLEN + REG_ADDR_W;
    // MUX3_select, regwrite_enable, mem_read, mem_write, ALU_out, store data, rd
    localparam int unsigned EX_MA_PAYLOAD_W = 4 + 2 * XLEN + REG_ADDR_W;
    localparam int unsigned MA_WB_PAYLOAD_W = 71;

    localparam int unsigned MA_WB_RD_LSB        = 0;
    localparam int unsigned MA_WB_READ_DATA_LSB = 5;
    localparam int unsigned MA_WB_ALU_OUT_LSB   = 37;
    localparam int unsigned MA_WB_REGWRITE_LSB  = 69;
    localparam int unsigned MA_WB_MUX3_SEL_LSB  = 70;

    typedef struct packed {
        logic                  mux3_select;
        logic                  regwrite_enable;
        logic [XLEN-1:0]       alu_out;
        logic [XLEN-1:0]       read_data;
        logic [REG_ADDR_W-1:0] rd;
    } ma_wb_t;

    // Where an accepted upstream payload lands in the skid configuration.
    typedef enum logic [1:0] {
        RouteNone = 2'd0,
        RouteMain = 2'd1,
        RouteSkid = 2'd2
    } in_route_e;

    function automatic logic [MA_WB_PAYLOAD_W-1:0] pack_ma_wb(input ma_wb_t f);
        logic [MA_WB_PAYLOAD_W-1:0] p;
        p = '0;
        p[MA_WB_RD_LSB +: REG_ADDR_W]  = f.rd;
        p[MA_WB_READ_DATA_LSB +: XLEN] = f.read_data;
        p[MA_WB_ALU_OUT_LSB +: XLEN]   = f.alu_out;
        p[MA_WB_REGWRITE_LSB]          = f.regwrite_enable;
        p[MA_WB_MUX3_SEL_LSB]          = f.mux3_select;
        return p;
    endfunction

    function automatic ma_wb_t unpack_ma_wb(input logic [MA_WB_PAYLOAD_W-1:0] p);
        ma_wb_t f;
        f.rd              = p[MA_WB_RD_LSB +: REG_ADDR_W];
        f.read_data       = p[MA_WB_READ_DATA_LSB +: XLEN];
        f.alu_out         = p[MA_WB_ALU_OUT_LSB +: XLEN];
        f.regwrite_enable = p[MA_WB_REGWRITE_LSB];
        f.mux3_select     = p[MA_WB_MUX3_SEL_LSB];
        return f;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: payload register plus valid flag.
// clear beats load; the payload is only written on a successful load.
module pipe_slot #(
    parameter int unsigned PAYLOAD_W = 71
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 load,
    input  logic                 clear,
    input  logic [PAYLOAD_W-1:0] load_data,
    output logic [PAYLOAD_W-1:0] data,
    output logic                 valid
);

    logic [PAYLOAD_W-1:0] data_q;
    logic                 valid_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (clear) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
                data_q  <= load_data;
            end
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with flush, optional two-entry skid
// buffer (registered in_ready) and optional zeroing of the payload on bubbles.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W       = MA_WB_PAYLOAD_W,
    parameter int unsigned SKID            = 0,
    parameter int unsigned CLEAR_ON_BUBBLE = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy
);

    logic                 main_load;
    logic                 main_clear;
    logic [PAYLOAD_W-1:0] main_load_data;
    logic [PAYLOAD_W-1:0] main_data;
    logic                 main_valid;
    logic                 skid_valid;

    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_main_slot (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (main_load),
        .clear     (main_clear),
        .load_data (main_load_data),
        .data      (main_data),
        .valid     (main_valid)
    );

    if (SKID == 0) begin : g_single
        logic accept;
        logic drain;

        assign skid_valid = 1'b0;

        always_comb begin
            in_ready       = !main_valid || out_ready;
            accept         = in_valid && in_ready;
            drain          = main_valid && out_ready;
            main_load_data = in_payload;
            main_load      = accept && !flush;
            // A same-edge accept overwrites the drained entry, so only clear when idle.
            main_clear     = flush || (drain && !accept);
        end
    end else begin : g_skid
        logic                 in_ready_q;
        logic                 in_ready_d;
        logic                 accept;
        logic                 drain;
        logic                 skid_load;
        logic                 skid_clear;
        logic                 skid_valid_next;
        logic [PAYLOAD_W-1:0] skid_data;
        in_route_e            route;

        pipe_slot #(
            .PAYLOAD_W (PAYLOAD_W)
        ) u_skid_slot (
            .CLK       (CLK),
            .RESET     (RESET),
            .load      (skid_load),
            .clear     (skid_clear),
            .load_data (in_payload),
            .data      (skid_data),
            .valid     (skid_valid)
        );

        always_comb begin
            accept = in_valid && in_ready_q;
            drain  = main_valid && out_ready;

            route = RouteNone;
            if (accept) begin
                if (!main_valid || (drain && !skid_valid)) begin
                    route = RouteMain;
                end else begin
                    route = RouteSkid;
                end
            end

            // in_ready_q low whenever skid is full, so a refill from skid never
            // coincides with an upstream accept.
            main_load_data = skid_valid ? skid_data : in_payload;
            main_load      = !flush && ((route == RouteMain) || (drain && skid_valid));
            main_clear     = flush || (drain && !skid_valid && (route != RouteMain));

            skid_load  = !flush && (route == RouteSkid);
            skid_clear = flush || (drain && skid_valid);

            skid_valid_next = !flush && (skid_load || (skid_valid && !drain));
            in_ready_d      = !skid_valid_next;
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready = in_ready_q;
    end

    always_comb begin
        out_valid   = main_valid;
        out_payload = main_data;
        if ((CLEAR_ON_BUBBLE != 0) && !main_valid) begin
            out_payload = '0;
        end
        occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random-handshake bench for pipe_stage_reg; instance 0 is SKID=0,
// instance 1 is SKID=1, both clearing the payload on bubbles.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int W = MA_WB_PAYLOAD_W;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic [1:0]        flush;
    logic [1:0]        in_valid;
    logic [1:0]        out_ready;
    logic [1:0][W-1:0] in_payload;
    logic [1:0]        in_ready;
    logic [1:0]        out_valid;
    logic [1:0][W-1:0] out_payload;
    logic [1:0][1:0]   occupancy;

    int checks = 0;
    int errors = 0;

    // Reference model: a bounded FIFO per instance.
    int         cnt [2];
    logic [W-1:0] mq [2][2];

    pipe_stage_reg #(
        .PAYLOAD_W       (W),
        .SKID            (0),
        .CLEAR_ON_BUBBLE (1)
    ) u_dut0 (
        .CLK         (CLK),
        .RESET       (RESET),
        .flush       (flush[0]),
        .in_valid    (in_valid[0]),
        .in_ready    (in_ready[0]),
        .in_payload  (in_payload[0]),
        .out_valid   (out_valid[0]),
        .out_ready   (out_ready[0]),
        .out_payload (out_payload[0]),
        .occupancy   (occupancy[0])
    );

    pipe_stage_reg #(
        .PAYLOAD_W       (W),
        .SKID            (1),
        .CLEAR_ON_BUBBLE (1)
    ) u_dut1 (
        .CLK         (CLK),
        .RESET       (RESET),
        .flush       (flush[1]),
        .in_valid    (in_valid[1]),
        .in_ready    (in_ready[1]),
        .in_payload  (in_payload[1]),
        .out_valid   (out_valid[1]),
        .out_ready   (out_ready[1]),
        .out_payload (out_payload[1]),
        .occupancy   (occupancy[1])
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic exp_ready(input int m);
        if (m == 0) return (cnt[0] == 0) || out_ready[0];
        return cnt[1] < 2;
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            logic acc;
            logic drn;
            acc = in_valid[m] && exp_ready(m);
            drn = (cnt[m] > 0) && out_ready[m];
            if (flush[m]) begin
                cnt[m] = 0;
            end else begin
                if (drn) begin
                    mq[m][0] = mq[m][1];
                    cnt[m]--;
                end
                if (acc) begin
                    mq[m][cnt[m]] = in_payload[m];
                    cnt[m]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [W-1:0] exp_pl;
            exp_pl = (cnt[m] > 0) ? mq[m][0] : '0;
            check($sformatf("m%0d out_valid", m), W'(out_valid[m]), W'(cnt[m] > 0));
            check($sformatf("m%0d out_payload", m), out_payload[m], exp_pl);
            check($sformatf("m%0d occupancy", m), W'(occupancy[m]), W'(cnt[m]));
            check($sformatf("m%0d in_ready", m), W'(in_ready[m]), W'(exp_ready(m)));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic idle();
        flush      = '0;
        in_valid   = '0;
        out_ready  = '0;
        in_payload = '0;
    endtask

    initial begin
        logic [95:0] rnd;
        logic [W-1:0] mawb;
        idle();
        cnt[0] = 0;
        cnt[1] = 0;

        // Reset state
        #2;
        check("rst occ0", W'(occupancy[0]), '0);
        check("rst occ1", W'(occupancy[1]), '0);
        check("rst pl1", out_payload[1], '0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check_all();

        // 1. Streaming through SKID=0
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[0]   = 1'b1;
            in_payload[0] = W'(8'h11 + i);
            tick();
            check("stream pl", out_payload[0], W'(8'h11 + i));
            check("stream occ", W'(occupancy[0]), W'(1));
        end
        in_valid[0] = 1'b0;
        tick();

        // 2. Stall in SKID=1
        idle();
        in_valid[1]   = 1'b1;
        in_payload[1] = W'(8'hAA);
        tick();
        in_payload[1] = W'(8'hBB);
        tick();
        check("stall in_ready", W'(in_ready[1]), '0);
        check("stall occ", W'(occupancy[1]), W'(2));
        check("stall pl", out_payload[1], W'(8'hAA));
        in_payload[1] = W'(8'hCC);
        tick();
        check("stall hold", out_payload[1], W'(8'hAA));
        out_ready[1] = 1'b1;
        tick();
        check("drain pl bb", out_payload[1], W'(8'hBB));
        check("drain ready", W'(in_ready[1]), W'(1));
        tick();
        check("drain pl cc", out_payload[1], W'(8'hCC));
        in_valid[1] = 1'b0;
        tick();
        check("drain empty", W'(out_valid[1]), '0);

        // 3. Flush with a simultaneous upstream transfer on both instances
        idle();
        out_ready[0]  = 1'b1;
        in_valid      = 2'b11;
        in_payload[0] = W'(8'h01);
        in_payload[1] = W'(8'h01);
        tick();
        out_ready[0]  = 1'b0;
        in_payload[1] = W'(8'h02);
        tick();
        check("pre-flush occ", W'(occupancy[1]), W'(2));
        flush         = 2'b11;
        out_ready[0]  = 1'b1;
        in_payload[0] = W'(8'h55);
        in_payload[1] = W'(8'h55);
        tick();
        check("flush valid0", W'(out_valid[0]), '0);
        check("flush pl0", out_payload[0], '0);
        check("flush occ1", W'(occupancy[1]), '0);
        idle();
        tick();
        tick();

        // 4. Bubble clearing on MA/WB payload
        mawb = {1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd7};
        out_ready[0]  = 1'b1;
        in_valid[0]   = 1'b1;
        in_payload[0] = pack_ma_wb(unpack_ma_wb(mawb));
        tick();
        check("mawb pl", out_payload[0], mawb);
        check("mawb rd", W'(out_payload[0][MA_WB_RD_LSB +: REG_ADDR_W]), W'(7));
        in_valid[0] = 1'b0;
        tick();
        check("bubble regwrite", W'(out_payload[0][MA_WB_REGWRITE_LSB]), '0);

        // 5. Async reset mid-stall
        idle();
        in_valid[1]   = 1'b1;
        in_payload[1] = W'(8'h31);
        tick();
        in_payload[1] = W'(8'h32);
        tick();
        idle();
        check("pre-reset occ", W'(occupancy[1]), W'(2));
        #2;
        RESET = 1'b1;
        #1;
        check("arst valid", W'(out_valid[1]), '0);
        check("arst pl", out_payload[1], '0);
        check("arst occ", W'(occupancy[1]), '0);
        RESET = 1'b0;
        cnt[0] = 0;
        cnt[1] = 0;
        #1;
        check("arst ready", W'(in_ready[1]), W'(1));
        tick();
        in_valid[1]   = 1'b1;
        out_ready[1]  = 1'b1;
        in_payload[1] = W'(8'h77);
        tick();
        check("post-rst pl", out_payload[1], W'(8'h77));
        idle();
        tick();

        // 6. Random handshake on both instances
        for (int c = 0; c < 10000; c++) begin
            for (int m = 0; m < 2; m++) begin
                rnd           = {$urandom, $urandom, $urandom};
                in_valid[m]   = 1'($urandom_range(0, 1));
                out_ready[m]  = 1'($urandom_range(0, 1));
                flush[m]      = ($urandom_range(0, 31) == 0);
                in_payload[m] = rnd[W-1:0];
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
